// File: rtl/usb_rx_packet_decoder.sv
// USB full-speed packet decoder: validates SYNC/PID/token/CRC status from the byte stage,
// reports a packet code and streams DATA payload (CRC16 stripped) to the data buffer.
module usb_rx_packet_decoder #(
   parameter logic [6:0] DEV_ADDR    = 7'd0,
   parameter logic [3:0] ENDPOINT    = 4'd0,
   parameter int         MAX_PAYLOAD = 64
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   input  logic       eop,
   input  logic       crc5_ok,
   input  logic       crc16_ok,
   output logic [2:0] rx_packet,
   output logic       store_rx_packet_data,
   output logic [7:0] rx_data,
   output logic       flush
);

   localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);

   localparam logic [2:0] PKT_IDLE = 3'd0;
   localparam logic [2:0] PKT_DATA = 3'd1;
   localparam logic [2:0] PKT_OUT  = 3'd2;
   localparam logic [2:0] PKT_IN   = 3'd3;
   localparam logic [2:0] PKT_ACK  = 3'd4;
   localparam logic [2:0] PKT_NAK  = 3'd5;
   localparam logic [2:0] PKT_BAD  = 3'd6;

   typedef enum logic [3:0] {
      S_IDLE, S_WAIT_PID, S_TOK1, S_TOK2, S_TOK_EOP,
      S_HS_EOP, S_REPORT, S_DATA_ACC, S_BAD_DATA, S_DISCARD
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       rx_packet_q, rx_packet_d;
   logic             store_q, store_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             flush_q, flush_d;
   logic [2:0]       code_q, code_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       held_q, held_d;
   logic             bad_eop_q, bad_eop_d;

   logic [7:0] tok1_q;
   logic [2:0] tok2_q;
   logic [7:0] hold0_q, hold1_q;
   logic       tok1_en, tok2_en, shift_en;

   function automatic logic pid_ok(input logic [7:0] b);
      return b[7:4] == ~b[3:0];
   endfunction

   always_comb begin
      state_d     = state_q;
      rx_packet_d = PKT_IDLE;
      store_d     = 1'b0;
      rx_data_d   = rx_data_q;
      flush_d     = 1'b0;
      code_d      = code_q;
      cnt_d       = cnt_q;
      held_d      = held_q;
      bad_eop_d   = bad_eop_q;
      tok1_en     = 1'b0;
      tok2_en     = 1'b0;
      shift_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (byte_valid) state_d = (byte_data == 8'h80) ? S_WAIT_PID : S_DISCARD;
         end
         S_WAIT_PID: begin
            if (byte_valid) begin
               state_d = S_DISCARD;
               if (pid_ok(byte_data)) begin
                  case (byte_data[3:0])
                     4'b0001: begin code_d = PKT_OUT; state_d = S_TOK1;   end
                     4'b1001: begin code_d = PKT_IN;  state_d = S_TOK1;   end
                     4'b0010: begin code_d = PKT_ACK; state_d = S_HS_EOP; end
                     4'b1010: begin code_d = PKT_NAK; state_d = S_HS_EOP; end
                     4'b0011, 4'b1011: begin
                        state_d     = S_DATA_ACC;
                        rx_packet_d = PKT_DATA;
                        flush_d     = 1'b1;
                        cnt_d       = '0;
                        held_d      = 2'd0;
                     end
                     default: state_d = S_DISCARD;
                  endcase
               end
            end else if (eop) begin
               state_d = S_IDLE;
            end
         end
         S_TOK1: begin
            if (byte_valid) begin
               tok1_en = 1'b1;
               state_d = S_TOK2;
            end else if (eop) begin
               state_d = S_IDLE;
            end
         end
         S_TOK2: begin
            if (byte_valid) begin
               tok2_en = 1'b1;
               state_d = S_TOK_EOP;
            end else if (eop) begin
               state_d = S_IDLE;
            end
         end
         S_TOK_EOP: begin
            if (byte_valid) begin
               state_d = S_DISCARD;
            end else if (eop) begin
               if (crc5_ok && tok1_q[6:0] == DEV_ADDR && {tok2_q, tok1_q[7]} == ENDPOINT) begin
                  state_d     = S_REPORT;
                  rx_packet_d = code_q;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_HS_EOP: begin
            if (byte_valid) begin
               state_d = S_DISCARD;
            end else if (eop) begin
               state_d     = S_REPORT;
               rx_packet_d = code_q;
            end
         end
         S_REPORT: state_d = S_IDLE;
         S_DATA_ACC: begin
            rx_packet_d = PKT_DATA;
            if (byte_valid) begin
               // The two newest bytes are always held back: they may turn out to be the CRC16.
               if (held_q == 2'd2) begin
                  if (cnt_q == CNT_W'(MAX_PAYLOAD)) begin
                     state_d     = S_BAD_DATA;
                     rx_packet_d = PKT_BAD;
                     flush_d     = 1'b1;
                     bad_eop_d   = 1'b0;
                  end else begin
                     store_d   = 1'b1;
                     rx_data_d = hold0_q;
                     cnt_d     = cnt_q + CNT_W'(1);
                     shift_en  = 1'b1;
                  end
               end else begin
                  held_d   = held_q + 2'd1;
                  shift_en = 1'b1;
               end
            end else if (eop) begin
               if (held_q == 2'd2 && crc16_ok) begin
                  state_d     = S_IDLE;
                  rx_packet_d = PKT_IDLE;
               end else begin
                  state_d     = S_BAD_DATA;
                  rx_packet_d = PKT_BAD;
                  flush_d     = 1'b1;
                  bad_eop_d   = 1'b1;
               end
            end
         end
         S_BAD_DATA: state_d = (bad_eop_q || eop) ? S_IDLE : S_DISCARD;
         S_DISCARD: begin
            if (eop) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_IDLE;
         rx_packet_q <= PKT_IDLE;
         store_q     <= 1'b0;
         rx_data_q   <= 8'h00;
         flush_q     <= 1'b0;
         code_q      <= PKT_IDLE;
         cnt_q       <= '0;
         held_q      <= 2'd0;
         bad_eop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_packet_q <= rx_packet_d;
         store_q     <= store_d;
         rx_data_q   <= rx_data_d;
         flush_q     <= flush_d;
         code_q      <= code_d;
         cnt_q       <= cnt_d;
         held_q      <= held_d;
         bad_eop_q   <= bad_eop_d;
      end
   end

   // Byte holding registers; their contents are qualified by state and held_q.
   always_ff @(posedge clk) begin
      if (tok1_en) tok1_q <= byte_data;
      if (tok2_en) tok2_q <= byte_data[2:0];
      if (shift_en) begin
         hold0_q <= hold1_q;
         hold1_q <= byte_data;
      end
   end

   assign rx_packet            = rx_packet_q;
   assign store_rx_packet_data = store_q;
   assign rx_data              = rx_data_q;
   assign flush                = flush_q;

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Directed bench for usb_rx_packet_decoder: tokens, handshakes, DATA good/bad/overflow, reset abort.
module tb_usb_rx_packet_decoder;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       eop;
   logic       crc5_ok;
   logic       crc16_ok;
   logic [2:0] rx_packet;
   logic       store_rx_packet_data;
   logic [7:0] rx_data;
   logic       flush;

   int errors = 0;
   int checks = 0;

   // Written only by the monitor.
   int         store_n = 0;
   int         flush_n = 0;
   int         bad_n   = 0;
   logic [7:0] stored [0:255];

   always #5 clk = ~clk;

   usb_rx_packet_decoder #(.DEV_ADDR(7'd0), .ENDPOINT(4'd0), .MAX_PAYLOAD(64)) dut (
      .clk(clk), .n_rst(n_rst), .byte_valid(byte_valid), .byte_data(byte_data),
      .eop(eop), .crc5_ok(crc5_ok), .crc16_ok(crc16_ok), .rx_packet(rx_packet),
      .store_rx_packet_data(store_rx_packet_data), .rx_data(rx_data), .flush(flush)
   );

   always @(negedge clk) begin
      if (store_rx_packet_data) begin
         stored[store_n[7:0]] <= rx_data;
         store_n <= store_n + 1;
      end
      if (flush) flush_n <= flush_n + 1;
      if (rx_packet == 3'd6) bad_n <= bad_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_eop(input logic c5, input logic c16);
      eop      = 1'b1;
      crc5_ok  = c5;
      crc16_ok = c16;
      @(posedge clk);
      #1;
      eop = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int s0, f0, b0;

   initial begin
      n_rst = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      eop = 1'b0; crc5_ok = 1'b0; crc16_ok = 1'b0;
      idle(2);
      check("rst_rx_packet", 32'(rx_packet), 32'd0);
      check("rst_store", 32'(store_rx_packet_data), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'h00);
      check("rst_flush", 32'(flush), 32'd0);
      n_rst = 1'b1;
      idle(2);

      // OUT token, addr 0 ep 0
      send_byte(8'h80); send_byte(8'hE1); send_byte(8'h00); send_byte(8'hE8);
      check("out_before_eop", 32'(rx_packet), 32'd0);
      send_eop(1'b1, 1'b0);
      check("out_report", 32'(rx_packet), 32'd2);
      idle(1);
      check("out_one_cycle", 32'(rx_packet), 32'd0);
      idle(2);

      // IN token to address 5 is rejected, then IN to address 0 decoded
      send_byte(8'h80); send_byte(8'h69); send_byte(8'h05); send_byte(8'h00);
      send_eop(1'b1, 1'b0);
      check("in_wrong_addr", 32'(rx_packet), 32'd0);
      idle(1);
      check("in_wrong_addr_next", 32'(rx_packet), 32'd0);
      send_byte(8'h80); send_byte(8'h69); send_byte(8'h00); send_byte(8'h00);
      send_eop(1'b1, 1'b0);
      check("in_report", 32'(rx_packet), 32'd3);
      idle(1);
      check("in_one_cycle", 32'(rx_packet), 32'd0);

      // Token with bad CRC5 is dropped
      send_byte(8'h80); send_byte(8'hE1); send_byte(8'h00); send_byte(8'hE8);
      send_eop(1'b0, 1'b0);
      check("out_bad_crc5", 32'(rx_packet), 32'd0);
      idle(2);

      // Good DATA0 packet
      s0 = store_n; f0 = flush_n; b0 = bad_n;
      send_byte(8'h80); send_byte(8'hC3);
      check("data_pid_code", 32'(rx_packet), 32'd1);
      check("data_pid_flush", 32'(flush), 32'd1);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      check("data_mid_code", 32'(rx_packet), 32'd1);
      send_byte(8'hC1); send_byte(8'hC2);
      check("data_end_code", 32'(rx_packet), 32'd1);
      send_eop(1'b0, 1'b1);
      check("data_after_eop", 32'(rx_packet), 32'd0);
      idle(2);
      check("data_store_count", 32'(store_n - s0), 32'd3);
      check("data_byte0", 32'(stored[s0[7:0]]), 32'h11);
      check("data_byte1", 32'(stored[8'(s0 + 1)]), 32'h22);
      check("data_byte2", 32'(stored[8'(s0 + 2)]), 32'h33);
      check("data_flush_count", 32'(flush_n - f0), 32'd1);
      check("data_no_bad", 32'(bad_n - b0), 32'd0);

      // Same packet, CRC16 fails
      s0 = store_n; f0 = flush_n;
      send_byte(8'h80); send_byte(8'hC3);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'hC1); send_byte(8'hC2);
      send_eop(1'b0, 1'b0);
      check("badcrc_code", 32'(rx_packet), 32'd6);
      check("badcrc_flush", 32'(flush), 32'd1);
      idle(1);
      check("badcrc_code_next", 32'(rx_packet), 32'd0);
      check("badcrc_flush_next", 32'(flush), 32'd0);
      idle(1);
      check("badcrc_stores", 32'(store_n - s0), 32'd3);
      check("badcrc_flushes", 32'(flush_n - f0), 32'd2);

      // Zero-length DATA1
      s0 = store_n;
      send_byte(8'h80); send_byte(8'h4B); send_byte(8'hAA); send_byte(8'hBB);
      send_eop(1'b0, 1'b1);
      check("zlp_code", 32'(rx_packet), 32'd0);
      idle(1);
      check("zlp_stores", 32'(store_n - s0), 32'd0);

      // DATA with one byte: too short
      send_byte(8'h80); send_byte(8'hC3); send_byte(8'h55);
      send_eop(1'b0, 1'b1);
      check("short_code", 32'(rx_packet), 32'd6);
      idle(2);

      // Overflow: 65 payload bytes + 2 CRC, then 2 trailing bytes
      s0 = store_n; b0 = bad_n; f0 = flush_n;
      send_byte(8'h80); send_byte(8'hC3);
      for (int i = 0; i < 65; i++) send_byte(8'(i));
      send_byte(8'hE0);
      send_byte(8'hE1);
      check("ovf_code", 32'(rx_packet), 32'd6);
      send_byte(8'hE2);
      send_byte(8'hE3);
      send_eop(1'b0, 1'b1);
      check("ovf_after_eop", 32'(rx_packet), 32'd0);
      idle(2);
      check("ovf_stores", 32'(store_n - s0), 32'd64);
      check("ovf_last_byte", 32'(stored[8'(s0 + 63)]), 32'd63);
      check("ovf_bad_once", 32'(bad_n - b0), 32'd1);
      check("ovf_flushes", 32'(flush_n - f0), 32'd2);
      check("ovf_state_idle", 32'(rx_packet), 32'd0);

      // PID with bad complement
      b0 = bad_n;
      send_byte(8'h80); send_byte(8'hD3);
      send_eop(1'b0, 1'b1);
      check("badpid_code", 32'(rx_packet), 32'd0);
      idle(1);
      check("badpid_code_next", 32'(rx_packet), 32'd0);
      check("badpid_no_bad", 32'(bad_n - b0), 32'd0);

      // Asynchronous reset mid-DATA, right as a store is presented
      f0 = flush_n;
      send_byte(8'h80); send_byte(8'hC3);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      check("pre_rst_store", 32'(store_rx_packet_data), 32'd1);
      n_rst = 1'b0;
      #1;
      check("arst_rx_packet", 32'(rx_packet), 32'd0);
      check("arst_store", 32'(store_rx_packet_data), 32'd0);
      check("arst_rx_data", 32'(rx_data), 32'h00);
      check("arst_flush", 32'(flush), 32'd0);
      idle(2);
      n_rst = 1'b1;
      idle(1);
      check("arst_no_flush", 32'(flush_n - f0), 32'd1);

      // ACK handshake after reset
      send_byte(8'h80); send_byte(8'hD2);
      send_eop(1'b0, 1'b0);
      check("ack_report", 32'(rx_packet), 32'd4);
      idle(1);
      check("ack_one_cycle", 32'(rx_packet), 32'd0);

      // NAK handshake
      send_byte(8'h80); send_byte(8'h5A);
      send_eop(1'b0, 1'b0);
      check("nak_report", 32'(rx_packet), 32'd5);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
